// File: rtl/noc_endpoint_ni.sv
// noc_endpoint_ni
// Network interface between a traffic-generating processing element (PE) and
// its router port.
//
// Injection path: PE requests are queued in a small FIFO. The head flit is
// sent to the router only when the credit counter of its VC is non-zero.
// Order is strict, so a credit-starved head blocks every flit behind it.
//
// Ejection path: router flits are buffered. They are handed to the PE with a
// valid/ready handshake, and one credit is returned per consumed flit.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   req_valid / req_ready           PE injection handshake (ready = FIFO not full)
//   req_tail/dest/vc/data           injected flit fields
//   flit_out                        registered flit to router {valid,tail,dest,vc,data}
//   credit_in                       {valid, vc} credit from router
//   flit_in                         flit from router, MSB = valid
//   credit_out                      registered {valid, vc} credit to router
//   ej_valid / ej_ready             PE ejection handshake
//   ej_tail/dest/vc/data            head of ejection FIFO (zero when empty)
//   credit_err                      sticky: credit returned to a full counter
//   ej_overflow                     sticky: flit dropped on a full ejection FIFO
module noc_endpoint_ni #(
  parameter int NUM_VCS           = 2,
  parameter int FLIT_DATA_WIDTH   = 32,
  parameter int DEST_BITS         = 4,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int INJ_DEPTH         = 4,
  localparam int VC_BITS          = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int FLIT_W           = 2 + FLIT_DATA_WIDTH + DEST_BITS + VC_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_tail,
  input  logic [DEST_BITS-1:0]       req_dest,
  input  logic [VC_BITS-1:0]         req_vc,
  input  logic [FLIT_DATA_WIDTH-1:0] req_data,
  output logic [FLIT_W-1:0]          flit_out,
  input  logic [VC_BITS:0]           credit_in,
  input  logic [FLIT_W-1:0]          flit_in,
  output logic [VC_BITS:0]           credit_out,
  output logic                       ej_valid,
  input  logic                       ej_ready,
  output logic                       ej_tail,
  output logic [DEST_BITS-1:0]       ej_dest,
  output logic [VC_BITS-1:0]         ej_vc,
  output logic [FLIT_DATA_WIDTH-1:0] ej_data,
  output logic                       credit_err,
  output logic                       ej_overflow
);

  localparam int ENTRY_W  = FLIT_W - 1;  // {tail, dest, vc, data}
  localparam int CNT_W    = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int EJ_DEPTH = NUM_VCS * FLIT_BUFFER_DEPTH;
  localparam int IPW      = (INJ_DEPTH > 1) ? $clog2(INJ_DEPTH) : 1;
  localparam int EPW      = (EJ_DEPTH > 1) ? $clog2(EJ_DEPTH) : 1;
  localparam int ICW      = $clog2(INJ_DEPTH + 1);
  localparam int ECW      = $clog2(EJ_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLIT_BUFFER_DEPTH);

  // Pointer advance with explicit wrap, so non power-of-2 depths also work.
  function automatic logic [IPW-1:0] inj_ptr_inc(input logic [IPW-1:0] p);
    return (p == IPW'(INJ_DEPTH - 1)) ? {IPW{1'b0}} : p + IPW'(1'b1);
  endfunction

  function automatic logic [EPW-1:0] ej_ptr_inc(input logic [EPW-1:0] p);
    return (p == EPW'(EJ_DEPTH - 1)) ? {EPW{1'b0}} : p + EPW'(1'b1);
  endfunction

  // Injection FIFO state
  logic [ENTRY_W-1:0] inj_mem_q [INJ_DEPTH];
  logic [IPW-1:0]     inj_wr_q, inj_wr_d, inj_rd_q, inj_rd_d;
  logic [ICW-1:0]     inj_cnt_q, inj_cnt_d;
  logic               inj_full_s, inj_empty_s, inj_push_s, inj_pop_s;
  logic [ENTRY_W-1:0] inj_head_s;
  logic [VC_BITS-1:0] head_vc_s;

  // Credit state
  logic [CNT_W-1:0]   cnt_credit_q [NUM_VCS];
  logic [CNT_W-1:0]   cnt_credit_d [NUM_VCS];
  logic [NUM_VCS-1:0] send_hit_s, ret_hit_s;
  logic               credit_err_q, credit_err_d;
  logic [FLIT_W-1:0]  flit_out_q, flit_out_d;

  // Ejection FIFO state
  logic [ENTRY_W-1:0] ej_mem_q [EJ_DEPTH];
  logic [EPW-1:0]     ej_wr_q, ej_wr_d, ej_rd_q, ej_rd_d;
  logic [ECW-1:0]     ej_cnt_q, ej_cnt_d;
  logic               ej_full_s, ej_in_valid_s, ej_push_s, ej_pop_s;
  logic [ENTRY_W-1:0] ej_head_s;
  logic               ej_overflow_q, ej_overflow_d;
  logic [VC_BITS:0]   credit_out_q, credit_out_d;

  assign inj_full_s  = (inj_cnt_q == ICW'(INJ_DEPTH));
  assign inj_empty_s = (inj_cnt_q == {ICW{1'b0}});
  assign req_ready   = !inj_full_s;
  assign inj_push_s  = req_valid && !inj_full_s;
  assign inj_head_s  = inj_mem_q[inj_rd_q];
  assign head_vc_s   = inj_head_s[FLIT_DATA_WIDTH +: VC_BITS];
  // Sending is gated on credit, so a counter can never underflow.
  assign inj_pop_s   = !inj_empty_s && (cnt_credit_q[head_vc_s] != {CNT_W{1'b0}});

  assign ej_full_s     = (ej_cnt_q == ECW'(EJ_DEPTH));
  assign ej_valid      = (ej_cnt_q != {ECW{1'b0}});
  assign ej_pop_s      = ej_valid && ej_ready;
  assign ej_in_valid_s = flit_in[FLIT_W-1];
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign ej_push_s     = ej_in_valid_s && (!ej_full_s || ej_pop_s);
  assign ej_head_s     = ej_valid ? ej_mem_q[ej_rd_q] : {ENTRY_W{1'b0}};
  assign {ej_tail, ej_dest, ej_vc, ej_data} = ej_head_s;

  assign flit_out    = flit_out_q;
  assign credit_out  = credit_out_q;
  assign credit_err  = credit_err_q;
  assign ej_overflow = ej_overflow_q;

  // Injection FIFO pointer/count next state and the outgoing flit register input.
  always_comb begin
    inj_wr_d   = inj_wr_q;
    inj_rd_d   = inj_rd_q;
    inj_cnt_d  = inj_cnt_q;
    flit_out_d = {FLIT_W{1'b0}};
    if (inj_push_s) begin
      inj_wr_d = inj_ptr_inc(inj_wr_q);
    end else begin
      inj_wr_d = inj_wr_q;
    end
    if (inj_pop_s) begin
      inj_rd_d   = inj_ptr_inc(inj_rd_q);
      flit_out_d = {1'b1, inj_head_s};
    end else begin
      inj_rd_d   = inj_rd_q;
      flit_out_d = {FLIT_W{1'b0}};
    end
    case ({inj_push_s, inj_pop_s})
      2'b10:   inj_cnt_d = inj_cnt_q + ICW'(1'b1);
      2'b01:   inj_cnt_d = inj_cnt_q - ICW'(1'b1);
      default: inj_cnt_d = inj_cnt_q;
    endcase
  end

  // Per-VC decode of this cycle's send and credit return.
  always_comb begin
    send_hit_s = {NUM_VCS{1'b0}};
    ret_hit_s  = {NUM_VCS{1'b0}};
    for (int v = 0; v < NUM_VCS; v++) begin
      send_hit_s[v] = inj_pop_s && (head_vc_s == VC_BITS'(v));
      ret_hit_s[v]  = credit_in[VC_BITS] && (credit_in[VC_BITS-1:0] == VC_BITS'(v));
    end
  end

  // Credit counters: a send and a return on the same VC cancel out; a return to a full counter is an error.
  always_comb begin
    cnt_credit_d = cnt_credit_q;
    credit_err_d = credit_err_q;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (send_hit_s[v] && ret_hit_s[v]) begin
        cnt_credit_d[v] = cnt_credit_q[v];
      end else if (send_hit_s[v]) begin
        cnt_credit_d[v] = cnt_credit_q[v] - CNT_W'(1'b1);
      end else if (ret_hit_s[v]) begin
        if (cnt_credit_q[v] == CNT_MAX) begin
          cnt_credit_d[v] = cnt_credit_q[v];
          credit_err_d    = 1'b1;
        end else begin
          cnt_credit_d[v] = cnt_credit_q[v] + CNT_W'(1'b1);
        end
      end else begin
        cnt_credit_d[v] = cnt_credit_q[v];
      end
    end
  end

  // Ejection FIFO pointer/count next state, returned credit and overflow flag.
  always_comb begin
    ej_wr_d       = ej_wr_q;
    ej_rd_d       = ej_rd_q;
    ej_cnt_d      = ej_cnt_q;
    credit_out_d  = {(VC_BITS + 1){1'b0}};
    ej_overflow_d = ej_overflow_q;
    if (ej_push_s) begin
      ej_wr_d = ej_ptr_inc(ej_wr_q);
    end else begin
      ej_wr_d = ej_wr_q;
    end
    if (ej_pop_s) begin
      ej_rd_d      = ej_ptr_inc(ej_rd_q);
      credit_out_d = {1'b1, ej_head_s[FLIT_DATA_WIDTH +: VC_BITS]};
    end else begin
      ej_rd_d      = ej_rd_q;
      credit_out_d = {(VC_BITS + 1){1'b0}};
    end
    if (ej_in_valid_s && ej_full_s && !ej_pop_s) begin
      ej_overflow_d = 1'b1;
    end else begin
      ej_overflow_d = ej_overflow_q;
    end
    case ({ej_push_s, ej_pop_s})
      2'b10:   ej_cnt_d = ej_cnt_q + ECW'(1'b1);
      2'b01:   ej_cnt_d = ej_cnt_q - ECW'(1'b1);
      default: ej_cnt_d = ej_cnt_q;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (inj_push_s) begin
      inj_mem_q[inj_wr_q] <= {req_tail, req_dest, req_vc, req_data};
    end
    if (ej_push_s) begin
      ej_mem_q[ej_wr_q] <= flit_in[FLIT_W-2:0];
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_wr_q      <= {IPW{1'b0}};
      inj_rd_q      <= {IPW{1'b0}};
      inj_cnt_q     <= {ICW{1'b0}};
      ej_wr_q       <= {EPW{1'b0}};
      ej_rd_q       <= {EPW{1'b0}};
      ej_cnt_q      <= {ECW{1'b0}};
      for (int v = 0; v < NUM_VCS; v++) begin
        cnt_credit_q[v] <= CNT_MAX;
      end
      credit_err_q  <= 1'b0;
      ej_overflow_q <= 1'b0;
      flit_out_q    <= {FLIT_W{1'b0}};
      credit_out_q  <= {(VC_BITS + 1){1'b0}};
    end else begin
      inj_wr_q      <= inj_wr_d;
      inj_rd_q      <= inj_rd_d;
      inj_cnt_q     <= inj_cnt_d;
      ej_wr_q       <= ej_wr_d;
      ej_rd_q       <= ej_rd_d;
      ej_cnt_q      <= ej_cnt_d;
      cnt_credit_q  <= cnt_credit_d;
      credit_err_q  <= credit_err_d;
      ej_overflow_q <= ej_overflow_d;
      flit_out_q    <= flit_out_d;
      credit_out_q  <= credit_out_d;
    end
  end

endmodule
